// File: rtl/bt656_pattern_tx_if.sv
// BT.656 byte stream and field/frame status driven by the pattern transmitter.
interface bt656_pattern_tx_if;
  logic [7:0] d_out;
  logic       sof;
  logic       field;
  logic       field_toggle;
  logic [7:0] frame_cnt;

  modport master (
    output d_out,
    output sof,
    output field,
    output field_toggle,
    output frame_cnt
  );

  modport slave (
    input d_out,
    input sof,
    input field,
    input field_toggle,
    input frame_cnt
  );
endinterface

// File: rtl/bt656_pattern_tx.sv
// Free-running synthetic BT.656 (525/60, 8-bit 4:2:2) source with luma test patterns,
// used as a loopback stimulus for the capture path.
module bt656_pattern_tx #(
  parameter int unsigned ACTIVE_BYTES = 1440,
  parameter int unsigned HBLANK_BYTES = 268,
  parameter int unsigned FIELD0_LINES = 262,
  parameter int unsigned FIELD1_LINES = 263,
  parameter int unsigned VBLANK_LINES = 20
) (
  input  logic               cam1_pclk,
  input  logic               cam_resetn,
  input  logic [1:0]         pattern_sel,
  bt656_pattern_tx_if.master tx
);

  localparam int unsigned H_W        = 11;
  localparam int unsigned V_W        = 9;
  localparam int unsigned P_W        = 10;
  localparam int unsigned SAV_START  = 4 + HBLANK_BYTES;
  localparam int unsigned ACT_START  = SAV_START + 4;
  localparam int unsigned LINE_BYTES = ACT_START + ACTIVE_BYTES;

  localparam logic [1:0] PAT_RAMP = 2'd0;
  localparam logic [1:0] PAT_BARS = 2'd1;
  localparam logic [1:0] PAT_LINE = 2'd2;

  localparam logic [7:0] BLANK_CB = 8'h80;
  localparam logic [7:0] BLANK_Y  = 8'h10;
  localparam logic [7:0] FLAT_Y   = 8'hEB;

  // Counter state: the byte about to be emitted
  logic [H_W-1:0] h_cnt;
  logic [V_W-1:0] v_cnt;
  logic           f_q;
  logic [1:0]     pat_q;
  logic           frame_pend_q;

  // Registered outputs
  logic [7:0] d_out_q;
  logic       sof_q;
  logic       field_q;
  logic       field_toggle_q;
  logic [7:0] frame_cnt_q;

  logic           line_end_c;
  logic           field_end_c;
  logic           sof_c;
  logic           v_blank_c;
  logic [V_W-1:0] last_line_c;
  logic [H_W-1:0] a_c;
  logic [P_W-1:0] pix_c;
  logic [7:0]     luma_raw_c;
  logic [7:0]     luma_c;
  logic [7:0]     byte_c;

  function automatic logic [7:0] xy_code(input logic f, input logic v, input logic h);
    return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h};
  endfunction

  // Line/field position decode
  always_comb begin
    last_line_c = f_q ? V_W'(FIELD1_LINES - 1) : V_W'(FIELD0_LINES - 1);
    line_end_c  = (h_cnt == H_W'(LINE_BYTES - 1));
    field_end_c = line_end_c && (v_cnt == last_line_c);
    sof_c       = (h_cnt == '0) && (v_cnt == '0);
    v_blank_c   = (v_cnt < V_W'(VBLANK_LINES));
  end

  // Luma per pattern, wrapped to 8 bits, then kept off the reserved 00/FF codes
  always_comb begin
    a_c        = h_cnt - H_W'(ACT_START);
    pix_c      = a_c[H_W-1:1];
    luma_raw_c = FLAT_Y;
    case (pat_q)
      PAT_RAMP: luma_raw_c = pix_c[7:0] + frame_cnt_q;
      PAT_BARS: luma_raw_c = 8'h10 + {pix_c[9:7], 5'b0_0000};
      PAT_LINE: luma_raw_c = v_cnt[7:0];
      default:  luma_raw_c = FLAT_Y;
    endcase
    luma_c = luma_raw_c;
    if (luma_raw_c == 8'h00) begin
      luma_c = 8'h01;
    end else if (luma_raw_c == 8'hFF) begin
      luma_c = 8'hFE;
    end
  end

  // Byte selection across EAV, horizontal blanking, SAV and the active window
  always_comb begin
    byte_c = BLANK_CB;
    if (h_cnt < H_W'(4)) begin
      case (h_cnt[1:0])
        2'd0:    byte_c = 8'hFF;
        2'd3:    byte_c = xy_code(f_q, v_blank_c, 1'b1);
        default: byte_c = 8'h00;
      endcase
    end else if (h_cnt < H_W'(SAV_START)) begin
      byte_c = h_cnt[0] ? BLANK_Y : BLANK_CB;
    end else if (h_cnt < H_W'(ACT_START)) begin
      case (h_cnt[1:0] - 2'(SAV_START))
        2'd0:    byte_c = 8'hFF;
        2'd3:    byte_c = xy_code(f_q, v_blank_c, 1'b0);
        default: byte_c = 8'h00;
      endcase
    end else if (!a_c[0]) begin
      byte_c = BLANK_CB;
    end else if (v_blank_c) begin
      byte_c = BLANK_Y;
    end else begin
      byte_c = luma_c;
    end
  end

  // Counters and registered outputs
  always_ff @(posedge cam1_pclk or negedge cam_resetn) begin
    if (!cam_resetn) begin
      h_cnt          <= '0;
      v_cnt          <= '0;
      f_q            <= 1'b0;
      pat_q          <= PAT_RAMP;
      frame_pend_q   <= 1'b0;
      d_out_q        <= BLANK_CB;
      sof_q          <= 1'b0;
      field_q        <= 1'b0;
      field_toggle_q <= 1'b0;
      frame_cnt_q    <= '0;
    end else begin
      d_out_q <= byte_c;
      sof_q   <= sof_c;
      field_q <= f_q;

      // Pattern and frame count only change on a field start so a field is uniform
      if (sof_c) begin
        pat_q          <= pattern_sel;
        field_toggle_q <= ~field_toggle_q;
        if (frame_pend_q) begin
          frame_cnt_q  <= frame_cnt_q + 8'd1;
          frame_pend_q <= 1'b0;
        end
      end

      if (line_end_c) begin
        h_cnt <= '0;
        if (field_end_c) begin
          v_cnt <= '0;
          f_q   <= ~f_q;
          if (f_q) begin
            frame_pend_q <= 1'b1;
          end
        end else begin
          v_cnt <= v_cnt + V_W'(1);
        end
      end else begin
        h_cnt <= h_cnt + H_W'(1);
      end
    end
  end

  assign tx.d_out        = d_out_q;
  assign tx.sof          = sof_q;
  assign tx.field        = field_q;
  assign tx.field_toggle = field_toggle_q;
  assign tx.frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_bt656_pattern_tx.sv
// Self-checking bench for bt656_pattern_tx using a short-field geometry and a stream position model.
module tb_bt656_pattern_tx;

  localparam int ACT    = 1440;
  localparam int HB     = 268;
  localparam int F0     = 3;
  localparam int F1     = 4;
  localparam int VB     = 1;
  localparam int LINE   = ACT + HB + 8;
  localparam int F0B    = F0 * LINE;
  localparam int FRAMEB = (F0 + F1) * LINE;

  logic       cam1_pclk   = 1'b0;
  logic       cam_resetn  = 1'b1;
  logic [1:0] pattern_sel = 2'd0;

  bt656_pattern_tx_if tx ();

  bt656_pattern_tx #(
    .ACTIVE_BYTES (ACT),
    .HBLANK_BYTES (HB),
    .FIELD0_LINES (F0),
    .FIELD1_LINES (F1),
    .VBLANK_LINES (VB)
  ) dut (
    .cam1_pclk   (cam1_pclk),
    .cam_resetn  (cam_resetn),
    .pattern_sel (pattern_sel),
    .tx          (tx)
  );

  always #5 cam1_pclk = ~cam1_pclk;

  int         errors = 0;
  int         checks = 0;
  int         k = -1;
  logic [1:0] field_pat = 2'd0;
  logic [1:0] sel_before = 2'd0;

  // Stream position model: byte index k since reset release -> frame/field/line/byte
  function automatic int frame_of(input int kk); return kk / FRAMEB; endfunction
  function automatic int field_of(input int kk); return ((kk % FRAMEB) >= F0B) ? 1 : 0; endfunction
  function automatic int line_of(input int kk);
    int pos = kk % FRAMEB;
    return (pos < F0B) ? pos / LINE : (pos - F0B) / LINE;
  endfunction
  function automatic int h_of(input int kk); return (kk % FRAMEB) % LINE; endfunction
  function automatic int kpos(input int fr, input int f, input int ln, input int h);
    return fr * FRAMEB + f * F0B + ln * LINE + h;
  endfunction

  function automatic logic [7:0] xy_ref(input int f, input int v, input int h);
    return 8'(128 + 64 * f + 32 * v + 16 * h + 8 * (v ^ h) + 4 * (f ^ h) + 2 * (f ^ v) + (f ^ v ^ h));
  endfunction

  function automatic logic [7:0] exp_byte(input int kk, input logic [1:0] pat);
    int h  = h_of(kk);
    int ln = line_of(kk);
    int f  = field_of(kk);
    int v  = (ln < VB) ? 1 : 0;
    int a, p, y;
    if (h == 0 || h == HB + 4) return 8'hFF;
    if (h == 1 || h == 2 || h == HB + 5 || h == HB + 6) return 8'h00;
    if (h == 3) return xy_ref(f, v, 1);
    if (h == HB + 7) return xy_ref(f, v, 0);
    if (h < HB + 4) return ((h - 4) % 2 == 0) ? 8'h80 : 8'h10;
    a = h - HB - 8;
    if (a % 2 == 0) return 8'h80;
    if (v == 1) return 8'h10;
    p = a / 2;
    case (pat)
      2'd0:    y = (p + frame_of(kk)) % 256;
      2'd1:    y = 16 + 32 * (p / 128);
      2'd2:    y = ln % 256;
      default: y = 235;
    endcase
    if (y == 0) y = 1;
    if (y == 255) y = 254;
    return 8'(y);
  endfunction

  // Advance one byte; remember which pattern_sel value the DUT sampled at a field start
  task automatic tick();
    sel_before = pattern_sel;
    @(posedge cam1_pclk);
    #1;
    k++;
    if (h_of(k) == 0 && line_of(k) == 0) field_pat = sel_before;
  endtask

  task automatic advance_to(input int target);
    while (k < target) tick();
  endtask

  task automatic test_reset();
    #2 cam_resetn = 1'b0;
    repeat (3) @(posedge cam1_pclk);
    #1;
    checks++; if (tx.d_out !== 8'h80) begin errors++; $display("FAIL reset_d_out: got %h want 80", tx.d_out); end
    checks++; if (tx.sof !== 1'b0) begin errors++; $display("FAIL reset_sof: got %b want 0", tx.sof); end
    checks++; if (tx.field !== 1'b0) begin errors++; $display("FAIL reset_field: got %b want 0", tx.field); end
    checks++; if (tx.field_toggle !== 1'b0) begin errors++; $display("FAIL reset_toggle: got %b want 0", tx.field_toggle); end
    checks++; if (tx.frame_cnt !== 8'h00) begin errors++; $display("FAIL reset_frame_cnt: got %h want 00", tx.frame_cnt); end
    cam_resetn = 1'b1;
    k = -1;
  endtask

  task automatic test_reset_release();
    logic [7:0] want [0:9];
    int         at   [0:9];
    want = '{8'hFF, 8'h00, 8'h00, 8'hB6, 8'h80, 8'h10, 8'hFF, 8'h00, 8'h00, 8'hAB};
    at   = '{0, 1, 2, 3, 4, 5, 272, 273, 274, 275};
    for (int i = 0; i < 276; i++) begin
      tick();
      for (int j = 0; j < 10; j++) begin
        if (at[j] == i) begin
          checks++;
          if (tx.d_out !== want[j]) begin errors++; $display("FAIL release_byte%0d: got %h want %h", i, tx.d_out, want[j]); end
        end
      end
      checks++;
      if (tx.sof !== ((i == 0) ? 1'b1 : 1'b0)) begin errors++; $display("FAIL release_sof%0d: got %b want %b", i, tx.sof, (i == 0)); end
    end
    checks++; if (tx.field !== 1'b0) begin errors++; $display("FAIL release_field: got %b want 0", tx.field); end
    checks++; if (tx.field_toggle !== 1'b1) begin errors++; $display("FAIL release_toggle: got %b want 1", tx.field_toggle); end
  endtask

  task automatic test_frame_counting();
    int         sk [3];
    logic       tg [3];
    logic [7:0] fc [3];
    int         n = 0;
    int         budget = 2 * FRAMEB;
    while (n < 3 && budget > 0) begin
      tick();
      budget--;
      if (tx.sof === 1'b1) begin
        sk[n] = k; tg[n] = tx.field_toggle; fc[n] = tx.frame_cnt; n++;
      end
    end
    checks++;
    if (n != 3) begin
      errors++; $display("FAIL frame_sof_timeout: got %0d pulses want 3", n);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (h_of(sk[i]) != 0 || line_of(sk[i]) != 0) begin errors++; $display("FAIL sof_position: got k=%0d want a field start", sk[i]); end
        checks++;
        if (fc[i] !== 8'(frame_of(sk[i]))) begin errors++; $display("FAIL frame_cnt_at_sof: got %0d want %0d", fc[i], frame_of(sk[i])); end
      end
      for (int i = 1; i < 3; i++) begin
        int want_len = (field_of(sk[i-1]) == 1) ? F1 * LINE : F0 * LINE;
        checks++;
        if (sk[i] - sk[i-1] != want_len) begin errors++; $display("FAIL sof_interval: got %0d want %0d", sk[i] - sk[i-1], want_len); end
        checks++;
        if (tg[i] !== ~tg[i-1]) begin errors++; $display("FAIL toggle_alternate: got %b want %b", tg[i], ~tg[i-1]); end
      end
    end
  endtask

  task automatic test_ramp();
    advance_to(kpos(1, 1, VB, HB + 8) - 1);
    checks++; if (tx.frame_cnt !== 8'd1) begin errors++; $display("FAIL ramp_frame_cnt: got %0d want 1", tx.frame_cnt); end
    for (int a = 0; a < ACT; a++) begin
      tick();
      if (a % 2 == 0) begin
        checks++;
        if (tx.d_out !== 8'h80) begin errors++; $display("FAIL ramp_chroma a=%0d: got %h want 80", a, tx.d_out); end
      end else if (a == 509) begin
        checks++;
        if (tx.d_out !== 8'hFE) begin errors++; $display("FAIL ramp_clamp_ff: got %h want FE", tx.d_out); end
      end else if (a == 511) begin
        checks++;
        if (tx.d_out !== 8'h01) begin errors++; $display("FAIL ramp_clamp_00: got %h want 01", tx.d_out); end
      end else if (a == 21) begin
        checks++;
        if (tx.d_out !== 8'd11) begin errors++; $display("FAIL ramp_pixel10: got %h want 0b", tx.d_out); end
      end
    end
  endtask

  task automatic test_line_codes();
    int         at   [0:5];
    logic [7:0] want [0:5];
    at   = '{kpos(2, 0, VB, 3), kpos(2, 0, VB, HB + 7), kpos(2, 1, 0, 3),
             kpos(2, 1, 0, HB + 7), kpos(2, 1, VB, 3), kpos(2, 1, VB, HB + 7)};
    want = '{8'h9D, 8'h80, 8'hF1, 8'hEC, 8'hDA, 8'hC7};
    for (int i = 0; i < 6; i++) begin
      advance_to(at[i]);
      checks++;
      if (tx.d_out !== want[i]) begin errors++; $display("FAIL line_code%0d: got %h want %h", i, tx.d_out, want[i]); end
    end
  endtask

  task automatic test_pattern_switch();
    int e0 = errors;
    pattern_sel = 2'd0;
    advance_to(kpos(3, 0, F0 - 1, HB + 8 + 200));
    pattern_sel = 2'd3;
    while (k < kpos(3, 1, 0, 0) - 1) begin
      tick();
      if (h_of(k) >= HB + 8 && (h_of(k) - HB - 8) % 2 == 1) begin
        checks++;
        if (tx.d_out !== exp_byte(k, 2'd0)) begin errors++; $display("FAIL switch_keeps_ramp k=%0d: got %h want %h", k, tx.d_out, exp_byte(k, 2'd0)); end
      end
    end
    while (k < kpos(3, 1, F1 - 1, LINE - 1) && errors - e0 < 16) begin
      tick();
      if (line_of(k) >= VB && h_of(k) >= HB + 8 && (h_of(k) - HB - 8) % 2 == 1) begin
        checks++;
        if (tx.d_out !== 8'hEB) begin errors++; $display("FAIL switch_flat k=%0d: got %h want EB", k, tx.d_out); end
      end
    end
  endtask

  task automatic test_bars_loopback();
    logic [7:0] bar_lut [0:5];
    logic       tog_prev;
    bar_lut = '{8'h10, 8'h30, 8'h50, 8'h70, 8'h90, 8'hB0};
    advance_to(kpos(4, 0, 0, 0) - 1);
    pattern_sel = 2'd1;
    tog_prev = tx.field_toggle;
    tick();
    checks++; if (tx.sof !== 1'b1) begin errors++; $display("FAIL bars_sof: got %b want 1", tx.sof); end
    checks++; if (tx.field_toggle !== ~tog_prev) begin errors++; $display("FAIL bars_toggle: got %b want %b", tx.field_toggle, ~tog_prev); end
    advance_to(kpos(4, 0, VB, HB + 8) - 1);
    for (int a = 0; a < ACT; a++) begin
      tick();
      if (a % 2 == 1) begin
        checks++;
        if (tx.d_out !== bar_lut[(a / 2) / 128]) begin errors++; $display("FAIL bars_luma p=%0d: got %h want %h", a / 2, tx.d_out, bar_lut[(a / 2) / 128]); end
      end
    end
  endtask

  task automatic test_random_stream();
    int e0 = errors;
    pattern_sel = 2'd2;
    for (int i = 0; i < FRAMEB; i++) begin
      if ($urandom_range(0, 2999) == 0) pattern_sel = 2'($urandom_range(0, 3));
      tick();
      checks++;
      if (tx.d_out !== exp_byte(k, field_pat)) begin errors++; $display("FAIL stream_d_out k=%0d: got %h want %h", k, tx.d_out, exp_byte(k, field_pat)); end
      checks++;
      if (tx.sof !== ((h_of(k) == 0 && line_of(k) == 0) ? 1'b1 : 1'b0)) begin errors++; $display("FAIL stream_sof k=%0d: got %b", k, tx.sof); end
      checks++;
      if (tx.field !== 1'(field_of(k))) begin errors++; $display("FAIL stream_field k=%0d: got %b want %0d", k, tx.field, field_of(k)); end
      checks++;
      if (tx.field_toggle !== 1'(((frame_of(k) * 2 + field_of(k)) % 2 == 0) ? 1 : 0)) begin errors++; $display("FAIL stream_toggle k=%0d: got %b", k, tx.field_toggle); end
      checks++;
      if (tx.frame_cnt !== 8'(frame_of(k))) begin errors++; $display("FAIL stream_frame_cnt k=%0d: got %0d want %0d", k, tx.frame_cnt, frame_of(k)); end
      if (errors - e0 > 16) break;
    end
  endtask

  task automatic test_reset_mid();
    int         n = $urandom_range(300, 1500);
    logic [7:0] want [0:3];
    want = '{8'hFF, 8'h00, 8'h00, 8'hB6};
    for (int i = 0; i < n; i++) tick();
    #2 cam_resetn = 1'b0;
    #1;
    checks++; if (tx.d_out !== 8'h80) begin errors++; $display("FAIL midreset_d_out: got %h want 80", tx.d_out); end
    checks++; if (tx.sof !== 1'b0) begin errors++; $display("FAIL midreset_sof: got %b want 0", tx.sof); end
    checks++; if (tx.field !== 1'b0) begin errors++; $display("FAIL midreset_field: got %b want 0", tx.field); end
    checks++; if (tx.field_toggle !== 1'b0) begin errors++; $display("FAIL midreset_toggle: got %b want 0", tx.field_toggle); end
    checks++; if (tx.frame_cnt !== 8'h00) begin errors++; $display("FAIL midreset_frame_cnt: got %h want 00", tx.frame_cnt); end
    repeat (2) @(posedge cam1_pclk);
    #3 cam_resetn = 1'b1;
    k = -1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (tx.d_out !== want[i]) begin errors++; $display("FAIL restart_byte%0d: got %h want %h", i, tx.d_out, want[i]); end
      checks++;
      if (tx.sof !== ((i == 0) ? 1'b1 : 1'b0)) begin errors++; $display("FAIL restart_sof%0d: got %b", i, tx.sof); end
    end
  endtask

  initial begin
    test_reset();
    test_reset_release();
    test_frame_counting();
    test_ramp();
    test_line_codes();
    test_pattern_switch();
    test_bars_loopback();
    test_random_stream();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
